// File: rtl/strassen_pkg.sv
// strassen_pkg: shared types, widths and constant operand tables for the Strassen engine.
package strassen_pkg;
   localparam int N_MAX = 8;
   localparam int EW    = 4;
   localparam int RW    = 12;
   localparam int IW    = 13;
   typedef logic signed [IW-1:0] sint_t;
   typedef enum logic [3:0] {
      IDLE  = 4'd0, CLR   = 4'd1, LDMEM = 4'd2, SLICE = 4'd3, BF    = 4'd4, CALC1 = 4'd5,
      CALC2 = 4'd6, COMB1 = 4'd7, COMB2 = 4'd8, WRITE = 4'd9, DONE  = 4'd10
   } state_e;
   function automatic logic [EW-1:0] a_tab(input int i, input int j);
      return EW'(i + j);
   endfunction
   function automatic logic [EW-1:0] b_tab(input int i, input int j);
      return (i == j) ? EW'(2) : EW'(1);
   endfunction
endpackage

// File: rtl/strassen2x2_core.sv
// strassen2x2_core: 2x2 Strassen leaf; latches operands, forms ten pre-sums,
// then evaluates M1..M4 and M5..M7 on two successive strobes.
module strassen2x2_core
   import strassen_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               slice_i,
   input  logic               bf_i,
   input  logic               calc1_i,
   input  logic               calc2_i,
   input  logic [3:0][EW-1:0] a_i,
   input  logic [3:0][EW-1:0] b_i,
   output sint_t              m1_o,
   output sint_t              m2_o,
   output sint_t              m3_o,
   output sint_t              m4_o,
   output sint_t              m5_o,
   output sint_t              m6_o,
   output sint_t              m7_o
);
   // operand index order: 0=x11, 1=x12, 2=x21, 3=x22
   sint_t a_q [4];
   sint_t b_q [4];
   sint_t s_q [10];
   sint_t s_d [10];
   sint_t m_q [7];
   sint_t m_d [7];
   always_comb begin
      s_d[0] = a_q[0] + a_q[3];
      s_d[1] = b_q[0] + b_q[3];
      s_d[2] = a_q[2] + a_q[3];
      s_d[3] = b_q[1] - b_q[3];
      s_d[4] = b_q[2] - b_q[0];
      s_d[5] = a_q[0] + a_q[1];
      s_d[6] = a_q[2] - a_q[0];
      s_d[7] = b_q[0] + b_q[1];
      s_d[8] = a_q[1] - a_q[3];
      s_d[9] = b_q[2] + b_q[3];
      m_d[0] = s_q[0] * s_q[1];
      m_d[1] = s_q[2] * b_q[0];
      m_d[2] = a_q[0] * s_q[3];
      m_d[3] = a_q[3] * s_q[4];
      m_d[4] = s_q[5] * b_q[3];
      m_d[5] = s_q[6] * s_q[7];
      m_d[6] = s_q[8] * s_q[9];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
         for (int i = 0; i < 10; i++) s_q[i] <= '0;
         for (int i = 0; i < 7; i++) m_q[i] <= '0;
      end else begin
         if (slice_i)
            for (int i = 0; i < 4; i++) begin
               a_q[i] <= {{(IW-EW){1'b0}}, a_i[i]};
               b_q[i] <= {{(IW-EW){1'b0}}, b_i[i]};
            end
         if (bf_i)
            for (int i = 0; i < 10; i++) s_q[i] <= s_d[i];
         if (calc1_i)
            for (int i = 0; i < 4; i++) m_q[i] <= m_d[i];
         if (calc2_i)
            for (int i = 4; i < 7; i++) m_q[i] <= m_d[i];
      end
   end
   assign m1_o = m_q[0];
   assign m2_o = m_q[1];
   assign m3_o = m_q[2];
   assign m4_o = m_q[3];
   assign m5_o = m_q[4];
   assign m6_o = m_q[5];
   assign m7_o = m_q[6];
endmodule

// File: rtl/top_strassen.sv
// top_strassen: blocked Strassen C = A x B over constant tables for n = 2, 4 or 8;
// FSM, operand tables, accumulators and the 8x8 result array live here.
module top_strassen
   import strassen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mode,
   output logic        done,
   output logic [3:0]  stateMM,
   output logic [11:0] memC_0,  memC_1,  memC_2,  memC_3,  memC_4,  memC_5,  memC_6,  memC_7,
   output logic [11:0] memC_8,  memC_9,  memC_10, memC_11, memC_12, memC_13, memC_14, memC_15,
   output logic [11:0] memC_16, memC_17, memC_18, memC_19, memC_20, memC_21, memC_22, memC_23,
   output logic [11:0] memC_24, memC_25, memC_26, memC_27, memC_28, memC_29, memC_30, memC_31,
   output logic [11:0] memC_32, memC_33, memC_34, memC_35, memC_36, memC_37, memC_38, memC_39,
   output logic [11:0] memC_40, memC_41, memC_42, memC_43, memC_44, memC_45, memC_46, memC_47,
   output logic [11:0] memC_48, memC_49, memC_50, memC_51, memC_52, memC_53, memC_54, memC_55,
   output logic [11:0] memC_56, memC_57, memC_58, memC_59, memC_60, memC_61, memC_62, memC_63,
   output logic        clrAll_tb,
   output logic        ldmemAB_tb,
   output logic        ldSlice_tb,
   output logic        ldBF_tb,
   output logic        ldCalc1_tb,
   output logic        ldCalc2_tb,
   output logic        ldComb1_tb,
   output logic        ldComb2_tb,
   output logic        we_tb,
   output logic [3:0]  addr_tb
);
   state_e state_q, state_d;
   logic [3:0] mode_q;
   logic [1:0] bi_q, bj_q, k_q;
   logic [N_MAX-1:0][N_MAX-1:0][EW-1:0] a_q, b_q;
   logic [N_MAX*N_MAX-1:0][RW-1:0] memc_q;
   sint_t acc11_q, acc12_q, acc21_q, acc22_q;
   sint_t m1, m2, m3, m4, m5, m6, m7;
   logic [3:0][EW-1:0] a_sl, b_sl;
   logic [1:0] lim;
   logic valid, last_k, last_blk;
   logic [5:0] wbase;
   // lim is the last block index along one dimension: n/2 - 1
   assign lim      = (mode_q == 4'd8) ? 2'd3 : (mode_q == 4'd4) ? 2'd1 : 2'd0;
   assign valid    = (mode_q == 4'd2) || (mode_q == 4'd4) || (mode_q == 4'd8);
   assign last_k   = k_q == lim;
   assign last_blk = (bi_q == lim) && (bj_q == lim);
   assign wbase    = {bi_q, 1'b0, bj_q, 1'b0};
   assign a_sl = {a_q[{bi_q, 1'b1}][{k_q, 1'b1}], a_q[{bi_q, 1'b1}][{k_q, 1'b0}],
                  a_q[{bi_q, 1'b0}][{k_q, 1'b1}], a_q[{bi_q, 1'b0}][{k_q, 1'b0}]};
   assign b_sl = {b_q[{k_q, 1'b1}][{bj_q, 1'b1}], b_q[{k_q, 1'b1}][{bj_q, 1'b0}],
                  b_q[{k_q, 1'b0}][{bj_q, 1'b1}], b_q[{k_q, 1'b0}][{bj_q, 1'b0}]};
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? CLR : IDLE;
         CLR:     state_d = LDMEM;
         LDMEM:   state_d = valid ? SLICE : DONE;
         SLICE:   state_d = BF;
         BF:      state_d = CALC1;
         CALC1:   state_d = CALC2;
         CALC2:   state_d = COMB1;
         COMB1:   state_d = COMB2;
         COMB2:   state_d = last_k ? WRITE : SLICE;
         WRITE:   state_d = last_blk ? DONE : SLICE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= '0;
         bi_q    <= '0;
         bj_q    <= '0;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         memc_q  <= '0;
         acc11_q <= '0;
         acc12_q <= '0;
         acc21_q <= '0;
         acc22_q <= '0;
      end else if (state_q == IDLE) begin
         if (start) mode_q <= mode;
      end else if (state_q == CLR) begin
         memc_q  <= '0;
         acc11_q <= '0;
         acc12_q <= '0;
         acc21_q <= '0;
         acc22_q <= '0;
         bi_q    <= '0;
         bj_q    <= '0;
         k_q     <= '0;
      end else if (state_q == LDMEM) begin
         for (int i = 0; i < N_MAX; i++)
            for (int j = 0; j < N_MAX; j++) begin
               a_q[i][j] <= a_tab(i, j);
               b_q[i][j] <= b_tab(i, j);
            end
      end else if (state_q == COMB1) begin
         acc11_q <= acc11_q + m1 + m4 - m5 + m7;
         acc12_q <= acc12_q + m3 + m5;
      end else if (state_q == COMB2) begin
         acc21_q <= acc21_q + m2 + m4;
         acc22_q <= acc22_q + m1 - m2 + m3 + m6;
         k_q     <= last_k ? 2'd0 : k_q + 2'd1;
      end else if (state_q == WRITE) begin
         memc_q[wbase]         <= RW'(acc11_q);
         memc_q[wbase + 6'd1]  <= RW'(acc12_q);
         memc_q[wbase + 6'd8]  <= RW'(acc21_q);
         memc_q[wbase + 6'd9]  <= RW'(acc22_q);
         acc11_q <= '0;
         acc12_q <= '0;
         acc21_q <= '0;
         acc22_q <= '0;
         bj_q    <= (bj_q == lim) ? 2'd0 : bj_q + 2'd1;
         bi_q    <= (bj_q != lim) ? bi_q : (bi_q == lim) ? 2'd0 : bi_q + 2'd1;
      end
   end
   strassen2x2_core u_core (
      .clk     (clk),
      .rst     (reset),
      .slice_i (state_q == SLICE),
      .bf_i    (state_q == BF),
      .calc1_i (state_q == CALC1),
      .calc2_i (state_q == CALC2),
      .a_i     (a_sl),
      .b_i     (b_sl),
      .m1_o    (m1),
      .m2_o    (m2),
      .m3_o    (m3),
      .m4_o    (m4),
      .m5_o    (m5),
      .m6_o    (m6),
      .m7_o    (m7)
   );
   assign done       = state_q == DONE;
   assign stateMM    = state_q;
   assign clrAll_tb  = state_q == CLR;
   assign ldmemAB_tb = state_q == LDMEM;
   assign ldSlice_tb = state_q == SLICE;
   assign ldBF_tb    = state_q == BF;
   assign ldCalc1_tb = state_q == CALC1;
   assign ldCalc2_tb = state_q == CALC2;
   assign ldComb1_tb = state_q == COMB1;
   assign ldComb2_tb = state_q == COMB2;
   assign we_tb      = state_q == WRITE;
   assign addr_tb    = (mode_q == 4'd8) ? {bi_q, bj_q} : (mode_q == 4'd4) ? {2'b00, bi_q[0], bj_q[0]} : 4'd0;
   assign {memC_63, memC_62, memC_61, memC_60, memC_59, memC_58, memC_57, memC_56,
           memC_55, memC_54, memC_53, memC_52, memC_51, memC_50, memC_49, memC_48,
           memC_47, memC_46, memC_45, memC_44, memC_43, memC_42, memC_41, memC_40,
           memC_39, memC_38, memC_37, memC_36, memC_35, memC_34, memC_33, memC_32,
           memC_31, memC_30, memC_29, memC_28, memC_27, memC_26, memC_25, memC_24,
           memC_23, memC_22, memC_21, memC_20, memC_19, memC_18, memC_17, memC_16,
           memC_15, memC_14, memC_13, memC_12, memC_11, memC_10, memC_9,  memC_8,
           memC_7,  memC_6,  memC_5,  memC_4,  memC_3,  memC_2,  memC_1,  memC_0} = memc_q;
endmodule

// File: tb/tb_top_strassen.sv
// tb_top_strassen: scoreboard bench; runs are queued with a plain-arithmetic matrix
// product and latency formula, and a monitor checks them whenever done pulses.
module tb_top_strassen;
   typedef logic [63:0][11:0] cvec_t;
   typedef struct {
      int    t0;
      int    lat;
      int    nwr;
      cvec_t c;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [3:0] mode = 4'd0;
   logic done;
   logic [3:0] stateMM, addr_tb;
   logic clrAll_tb, ldmemAB_tb, ldSlice_tb, ldBF_tb, ldCalc1_tb, ldCalc2_tb, ldComb1_tb, ldComb2_tb, we_tb;
   logic [11:0] memC_0,  memC_1,  memC_2,  memC_3,  memC_4,  memC_5,  memC_6,  memC_7;
   logic [11:0] memC_8,  memC_9,  memC_10, memC_11, memC_12, memC_13, memC_14, memC_15;
   logic [11:0] memC_16, memC_17, memC_18, memC_19, memC_20, memC_21, memC_22, memC_23;
   logic [11:0] memC_24, memC_25, memC_26, memC_27, memC_28, memC_29, memC_30, memC_31;
   logic [11:0] memC_32, memC_33, memC_34, memC_35, memC_36, memC_37, memC_38, memC_39;
   logic [11:0] memC_40, memC_41, memC_42, memC_43, memC_44, memC_45, memC_46, memC_47;
   logic [11:0] memC_48, memC_49, memC_50, memC_51, memC_52, memC_53, memC_54, memC_55;
   logic [11:0] memC_56, memC_57, memC_58, memC_59, memC_60, memC_61, memC_62, memC_63;
   cvec_t act;
   logic [8:0] strb;
   int tests = 0;
   int fails = 0;
   int edge_n = 0;
   int done_cnt = 0;
   exp_t sb[$];
   int wlog[$];
   exp_t me;

   top_strassen dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .done(done), .stateMM(stateMM),
      .memC_0(memC_0),   .memC_1(memC_1),   .memC_2(memC_2),   .memC_3(memC_3),   .memC_4(memC_4),   .memC_5(memC_5),   .memC_6(memC_6),   .memC_7(memC_7),
      .memC_8(memC_8),   .memC_9(memC_9),   .memC_10(memC_10), .memC_11(memC_11), .memC_12(memC_12), .memC_13(memC_13), .memC_14(memC_14), .memC_15(memC_15),
      .memC_16(memC_16), .memC_17(memC_17), .memC_18(memC_18), .memC_19(memC_19), .memC_20(memC_20), .memC_21(memC_21), .memC_22(memC_22), .memC_23(memC_23),
      .memC_24(memC_24), .memC_25(memC_25), .memC_26(memC_26), .memC_27(memC_27), .memC_28(memC_28), .memC_29(memC_29), .memC_30(memC_30), .memC_31(memC_31),
      .memC_32(memC_32), .memC_33(memC_33), .memC_34(memC_34), .memC_35(memC_35), .memC_36(memC_36), .memC_37(memC_37), .memC_38(memC_38), .memC_39(memC_39),
      .memC_40(memC_40), .memC_41(memC_41), .memC_42(memC_42), .memC_43(memC_43), .memC_44(memC_44), .memC_45(memC_45), .memC_46(memC_46), .memC_47(memC_47),
      .memC_48(memC_48), .memC_49(memC_49), .memC_50(memC_50), .memC_51(memC_51), .memC_52(memC_52), .memC_53(memC_53), .memC_54(memC_54), .memC_55(memC_55),
      .memC_56(memC_56), .memC_57(memC_57), .memC_58(memC_58), .memC_59(memC_59), .memC_60(memC_60), .memC_61(memC_61), .memC_62(memC_62), .memC_63(memC_63),
      .clrAll_tb(clrAll_tb), .ldmemAB_tb(ldmemAB_tb), .ldSlice_tb(ldSlice_tb), .ldBF_tb(ldBF_tb),
      .ldCalc1_tb(ldCalc1_tb), .ldCalc2_tb(ldCalc2_tb), .ldComb1_tb(ldComb1_tb), .ldComb2_tb(ldComb2_tb),
      .we_tb(we_tb), .addr_tb(addr_tb)
   );

   assign act = {memC_63, memC_62, memC_61, memC_60, memC_59, memC_58, memC_57, memC_56,
                 memC_55, memC_54, memC_53, memC_52, memC_51, memC_50, memC_49, memC_48,
                 memC_47, memC_46, memC_45, memC_44, memC_43, memC_42, memC_41, memC_40,
                 memC_39, memC_38, memC_37, memC_36, memC_35, memC_34, memC_33, memC_32,
                 memC_31, memC_30, memC_29, memC_28, memC_27, memC_26, memC_25, memC_24,
                 memC_23, memC_22, memC_21, memC_20, memC_19, memC_18, memC_17, memC_16,
                 memC_15, memC_14, memC_13, memC_12, memC_11, memC_10, memC_9,  memC_8,
                 memC_7,  memC_6,  memC_5,  memC_4,  memC_3,  memC_2,  memC_1,  memC_0};
   assign strb = {we_tb, ldComb2_tb, ldComb1_tb, ldCalc2_tb, ldCalc1_tb, ldBF_tb, ldSlice_tb, ldmemAB_tb, clrAll_tb};

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic bit is_valid(input int n);
      return n == 2 || n == 4 || n == 8;
   endfunction

   // plain row-by-column product over the constant tables, zero outside n x n
   function automatic cvec_t model(input int n);
      cvec_t c = '0;
      if (is_valid(n))
         for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
               int s = 0;
               for (int k = 0; k < n; k++) s += ((i + k) % 16) * ((k == j) ? 2 : 1);
               c[8*i+j] = 12'(s);
            end
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
      tests++;
      if (a !== x) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", nm, a, x);
      end
   endtask

   task automatic chkc(input string nm, input cvec_t a, input cvec_t x);
      tests++;
      if (a !== x) begin
         int k = 0;
         fails++;
         for (int i = 63; i >= 0; i--) if (a[i] !== x[i]) k = i;
         $display("FAIL %s: memC_%0d got %0d want %0d", nm, k, a[k], x[k]);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("strobes", strb, (stateMM >= 4'd1 && stateMM <= 4'd9) ? 9'd1 << (stateMM - 4'd1) : 9'd0);
         if (we_tb) wlog.push_back(int'(addr_tb));
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               bit ok;
               me = sb.pop_front();
               chk("latency", 64'(edge_n - me.t0), 64'(me.lat));
               chkc("result", act, me.c);
               ok = wlog.size() == me.nwr;
               foreach (wlog[i]) if (wlog[i] != i) ok = 1'b0;
               chk("write_order", 64'(ok), 1);
            end
            wlog.delete();
         end
      end
   end

   task automatic run(input logic [3:0] m, input bit poke, input bit gap);
      exp_t e;
      int d0;
      int n;
      n = int'(m);
      @(negedge clk);
      mode = m;
      start = 1'b1;
      e.t0 = edge_n + 1;
      e.lat = is_valid(n) ? 2 + (n / 2) * (n / 2) * (3 * n + 1) : 2;
      e.nwr = is_valid(n) ? (n / 2) * (n / 2) : 0;
      e.c = model(n);
      sb.push_back(e);
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      mode = 4'($urandom);
      for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
         start = poke && (i == 40);
         @(negedge clk);
      end
      start = 1'b0;
      if (done_cnt == d0) begin
         chk("done_timeout", 0, 1);
         sb.delete();
      end
      if (gap) begin
         repeat (3) @(negedge clk);
         chkc("hold", act, e.c);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_state", stateMM, 0);
      chk("rst_done", done, 0);
      chkc("rst_memc", act, '0);
      chk("rst_strobes", strb, 0);
      chk("rst_addr", addr_tb, 0);
      reset = 1'b0;
      run(4'd2, 1'b0, 1'b1);
      chk("m2_c0", memC_0, 1);
      chk("m2_c1", memC_1, 2);
      chk("m2_c8", memC_8, 4);
      chk("m2_c9", memC_9, 5);
      run(4'd4, 1'b0, 1'b1);
      chk("m4_c0", memC_0, 6);
      chk("m4_c27", memC_27, 24);
      run(4'd8, 1'b1, 1'b1);
      chk("m8_c0", memC_0, 28);
      chk("m8_c63", memC_63, 98);
      chk("m8_c7", memC_7, 35);
      @(negedge clk);
      mode = 4'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (150) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wlog.delete();
      chk("midrst_state", stateMM, 0);
      chkc("midrst_memc", act, '0);
      chk("midrst_addr", addr_tb, 0);
      run(4'd8, 1'b0, 1'b1);
      run(4'd3, 1'b0, 1'b1);
      for (int r = 0; r < 8; r++) begin
         int pick;
         logic [3:0] m;
         pick = $urandom_range(0, 3);
         m = (pick == 0) ? 4'd2 : (pick == 1) ? 4'd4 : (pick == 2) ? 4'd8 : 4'($urandom_range(9, 15));
         run(m, 1'($urandom), 1'($urandom));
      end
      run(4'd4, 1'b0, 1'b0);
      run(4'd2, 1'b0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
